// File: rtl/car_state_link_tx.sv
// Serial car-state transmitter: snapshots own-car collision centres, heading and speed on a frame
// request and sends them as a fixed 10-byte 8N1 UART frame (sync, seq, 7 payload bytes, XOR checksum).
module car_state_link_tx #(
    parameter int          CLK_FREQ     = 100_000_000,
    parameter int          BAUD         = 115_200,
    parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_req,
    input  logic [9:0]  my_f_x,
    input  logic [9:0]  my_f_y,
    input  logic [9:0]  my_r_x,
    input  logic [9:0]  my_r_y,
    input  logic [3:0]  angle_idx,
    input  logic [9:0]  speed,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  drop_cnt
);

    // A single-cycle bit period still needs a one-bit counter to keep the vector legal.
    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LAST_BYTE = 4'd9;
    localparam logic [2:0]       LAST_BIT  = 3'd7;
    localparam logic [7:0]       DROP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // XOR of the sequence byte and all seven payload bytes; the sync byte is not covered.
    function automatic logic [7:0] frame_checksum(input logic [7:0] seq, input logic [55:0] payload);
        logic [7:0] acc;
        acc = seq;
        for (int k = 0; k < 7; k++) begin
            acc = acc ^ payload[8*k +: 8];
        end
        return acc;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        bit_idx_r;
    logic [3:0]        byte_idx_r;
    logic [55:0]       payload_r;
    logic [7:0]        frame_seq_r;
    logic [7:0]        chk_r;
    logic [7:0]        seq_r;
    logic              tx_r;
    logic              busy_r;
    logic              frame_done_r;
    logic [7:0]        drop_cnt_r;

    logic [55:0]       payload_s;
    logic [7:0]        cur_byte_s;

    assign payload_s = {2'b00, speed, angle_idx, my_r_y, my_r_x, my_f_y, my_f_x};

    // Byte currently on the wire, selected from the latched snapshot.
    always_comb begin
        cur_byte_s = 8'hFF;
        case (byte_idx_r)
            4'd0:    cur_byte_s = SYNC_BYTE;
            4'd1:    cur_byte_s = frame_seq_r;
            4'd2:    cur_byte_s = payload_r[7:0];
            4'd3:    cur_byte_s = payload_r[15:8];
            4'd4:    cur_byte_s = payload_r[23:16];
            4'd5:    cur_byte_s = payload_r[31:24];
            4'd6:    cur_byte_s = payload_r[39:32];
            4'd7:    cur_byte_s = payload_r[47:40];
            4'd8:    cur_byte_s = payload_r[55:48];
            4'd9:    cur_byte_s = chk_r;
            default: cur_byte_s = 8'hFF;
        endcase
    end

    // Frame FSM with registered line, status and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            bit_idx_r    <= 3'd0;
            byte_idx_r   <= 4'd0;
            payload_r    <= 56'd0;
            frame_seq_r  <= 8'd0;
            chk_r        <= 8'd0;
            seq_r        <= 8'd0;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            drop_cnt_r   <= 8'd0;
        end else begin
            frame_done_r <= 1'b0;
            if (frame_req && busy_r && (drop_cnt_r != DROP_MAX)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (frame_req) begin
                        payload_r   <= payload_s;
                        frame_seq_r <= seq_r;
                        chk_r       <= frame_checksum(seq_r, payload_s);
                        seq_r       <= seq_r + 8'd1;
                        state_r     <= START;
                        busy_r      <= 1'b1;
                        tx_r        <= 1'b0;
                        cnt_r       <= CNT_ZERO;
                        byte_idx_r  <= 4'd0;
                        bit_idx_r   <= 3'd0;
                    end
                end
                START: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        state_r   <= DATA;
                        bit_idx_r <= 3'd0;
                        tx_r      <= cur_byte_s[0];
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= cur_byte_s[bit_idx_r + 3'd1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (byte_idx_r == LAST_BYTE) begin
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                            frame_done_r <= 1'b1;
                            tx_r         <= 1'b1;
                        end else begin
                            byte_idx_r <= byte_idx_r + 4'd1;
                            state_r    <= START;
                            tx_r       <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    tx_r    <= 1'b1;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_car_state_link_tx.sv
// Self-checking bench for car_state_link_tx: a frame-level reference model predicts the line every
// cycle, directed frames are decoded and compared with known byte vectors, and a fast instance checks seq wrap.
module tb_car_state_link_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 100 * CPB;

    logic       clk;
    logic       rst;
    logic       frame_req;
    logic [9:0] my_f_x, my_f_y, my_r_x, my_r_y, speed;
    logic [3:0] angle_idx;
    logic       tx, busy, frame_done;
    logic [7:0] drop_cnt;

    logic       rst_f, req_f;
    logic       tx_f, busy_f, done_f;
    logic [7:0] drop_f;

    car_state_link_tx #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .rst(rst), .frame_req(frame_req),
        .my_f_x(my_f_x), .my_f_y(my_f_y), .my_r_x(my_r_x), .my_r_y(my_r_y),
        .angle_idx(angle_idx), .speed(speed),
        .tx(tx), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    car_state_link_tx #(.CLKS_PER_BIT(1)) u_dut_fast (
        .clk(clk), .rst(rst_f), .frame_req(req_f),
        .my_f_x(my_f_x), .my_f_y(my_f_y), .my_r_x(my_r_x), .my_r_y(my_r_y),
        .angle_idx(angle_idx), .speed(speed),
        .tx(tx_f), .busy(busy_f), .frame_done(done_f), .drop_cnt(drop_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cycle   = 0;
    int   done_pulses = 0;

    // reference model state: whole-frame view (time into frame, bit list of the frame)
    bit   m_busy, m_done, m_tx;
    int   m_t, m_seq, m_drop;
    bit   m_bits[100];

    bit   cap_on;
    logic cap[0:1023];
    int   cap_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    function automatic void model_load(input logic [55:0] p, input int sq);
        logic [7:0] b[10];
        b[0] = 8'hA5;
        b[1] = 8'(sq);
        for (int k = 0; k < 7; k++) b[k+2] = p[8*k +: 8];
        b[9] = 8'h00;
        for (int k = 1; k <= 8; k++) b[9] = b[9] ^ b[k];
        for (int i = 0; i < 10; i++) begin
            m_bits[i*10] = 1'b0;
            for (int j = 0; j < 8; j++) m_bits[i*10 + 1 + j] = b[i][j];
            m_bits[i*10 + 9] = 1'b1;
        end
    endfunction

    task automatic tick();
        logic        r_s, q_s;
        logic [55:0] p_s;
        r_s = rst;
        q_s = frame_req;
        p_s = {2'b00, speed, angle_idx, my_r_y, my_r_x, my_f_y, my_f_x};
        @(posedge clk);
        #1;
        cycle++;
        if (r_s) begin
            m_busy = 1'b0; m_done = 1'b0; m_tx = 1'b1;
            m_t = 0; m_seq = 0; m_drop = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (q_s && m_drop < 255) m_drop++;
                m_t++;
                if (m_t == FRAME_CYC) begin
                    m_busy = 1'b0; m_done = 1'b1; m_tx = 1'b1;
                end else begin
                    m_tx = m_bits[m_t / CPB];
                end
            end else if (q_s) begin
                model_load(p_s, m_seq);
                m_seq  = (m_seq + 1) % 256;
                m_busy = 1'b1;
                m_t    = 0;
                m_tx   = m_bits[0];
            end else begin
                m_tx = 1'b1;
            end
        end
        check_eq("tx", {31'd0, tx}, {31'd0, m_tx});
        check_eq("busy", {31'd0, busy}, {31'd0, m_busy});
        check_eq("frame_done", {31'd0, frame_done}, {31'd0, m_done});
        check_eq("drop_cnt", {24'd0, drop_cnt}, m_drop);
        if (frame_done === 1'b1) done_pulses++;
        if (cap_on && cap_n < 1024) begin
            cap[cap_n] = tx;
            cap_n++;
        end
    endtask

    task automatic wait_done(input int budget, output int done_at);
        done_at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (frame_done === 1'b1) begin
                done_at = cycle;
                break;
            end
        end
        if (done_at < 0) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] cap_byte(input int i);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = cap[(i*10 + 1 + j) * CPB + CPB/2];
        return v;
    endfunction

    task automatic rand_inputs();
        my_f_x    = 10'($urandom_range(0, 1023));
        my_f_y    = 10'($urandom_range(0, 1023));
        my_r_x    = 10'($urandom_range(0, 1023));
        my_r_y    = 10'($urandom_range(0, 1023));
        speed     = 10'($urandom_range(0, 1023));
        angle_idx = 4'($urandom_range(0, 15));
    endtask

    task automatic zero_inputs();
        my_f_x = 10'd0; my_f_y = 10'd0; my_r_x = 10'd0; my_r_y = 10'd0;
        speed = 10'd0; angle_idx = 4'd0;
    endtask

    logic [79:0] exp1, exp2;
    logic [7:0]  sb;
    int          acc_cyc, done_at, f_off, f_cnt;
    bit          f_in, busy_f_prev;

    initial begin
        exp1 = 80'h2D_00_00_00_00_00_01_2C_00_A5;
        exp2 = 80'hF1_3F_CF_00_00_00_00_00_01_A5;
        rst = 1'b1; rst_f = 1'b1; req_f = 1'b0; frame_req = 1'b0;
        cap_on = 1'b0; cap_n = 0;
        zero_inputs();
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();

        // frame 1: f_x = 300
        my_f_x = 10'd300;
        done_pulses = 0; cap_n = 0; cap_on = 1'b1;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        acc_cyc = cycle;
        wait_done(FRAME_CYC + 50, done_at);
        check_eq("f1_len", done_at - acc_cyc, FRAME_CYC);
        repeat (5) tick();
        cap_on = 1'b0;
        check_eq("f1_done_pulses", done_pulses, 32'd1);
        for (int i = 0; i < 10; i++) check_eq($sformatf("f1_b%0d", i), {24'd0, cap_byte(i)}, {24'd0, exp1[8*i +: 8]});

        // frame 2: heading F, speed -4, inputs scrambled after acceptance, three rejected requests
        zero_inputs();
        angle_idx = 4'hF; speed = 10'h3FC;
        cap_n = 0; cap_on = 1'b1;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        done_at = -1;
        for (int off = 1; off < FRAME_CYC + 50; off++) begin
            if (off == 1) rand_inputs();
            frame_req = (off == 10 || off == 50 || off == 300);
            tick();
            if (frame_done === 1'b1) begin
                done_at = cycle;
                break;
            end
        end
        frame_req = 1'b0;
        if (done_at < 0) check_eq("f2_timeout", 32'd0, 32'd1);
        cap_on = 1'b0;
        check_eq("f2_drop3", {24'd0, drop_cnt}, 32'd3);
        for (int i = 0; i < 10; i++) check_eq($sformatf("f2_b%0d", i), {24'd0, cap_byte(i)}, {24'd0, exp2[8*i +: 8]});

        // frame 3: saturate the drop counter
        rand_inputs();
        frame_req = 1'b1;
        tick();
        repeat (300) tick();
        frame_req = 1'b0;
        wait_done(FRAME_CYC, done_at);
        check_eq("drop_sat", {24'd0, drop_cnt}, 32'd255);
        tick();

        // reset in the middle of B4, then the next frame restarts at seq 0
        rand_inputs();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        repeat (165) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        rand_inputs();
        cap_n = 0; cap_on = 1'b1;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        wait_done(FRAME_CYC + 50, done_at);
        cap_on = 1'b0;
        check_eq("rst_b0", {24'd0, cap_byte(0)}, 32'hA5);
        check_eq("rst_seq", {24'd0, cap_byte(1)}, 32'h00);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            frame_req = ($urandom_range(0, 99) < 3);
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        frame_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // request held high: back-to-back frames seq 0,1,2,3
        rand_inputs();
        done_pulses = 0;
        frame_req = 1'b1;
        repeat (3 * (FRAME_CYC + 1) + 5) tick();
        frame_req = 1'b0;
        check_eq("b2b_done_pulses", done_pulses, 32'd3);
        wait_done(FRAME_CYC + 50, done_at);
        tick();

        // seq wrap on the single-cycle-per-bit instance, request held high
        zero_inputs();
        tick();
        rst_f = 1'b0;
        req_f = 1'b1;
        f_cnt = 0; f_off = 0; f_in = 1'b0; busy_f_prev = 1'b0; sb = 8'h00;
        for (int i = 0; i < 257 * 101 + 200; i++) begin
            tick();
            if (busy_f && !busy_f_prev) begin
                f_in = 1'b1; f_off = 0;
                check_eq("wrap_start_bit", {31'd0, tx_f}, 32'd0);
            end else if (f_in) begin
                f_off++;
            end
            busy_f_prev = busy_f;
            if (f_in && f_off >= 11 && f_off <= 18) sb[f_off - 11] = tx_f;
            if (f_in && f_off == 18) begin
                check_eq("wrap_seq", {24'd0, sb}, f_cnt % 256);
                f_cnt++;
                f_in = 1'b0;
                if (f_cnt == 257) break;
            end
        end
        req_f = 1'b0;
        check_eq("wrap_frames", f_cnt, 32'd257);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
